// File: rtl/axi_ram_cmd_arb.sv
// Round-robin arbiter merging several RAM command streams onto one port.
// Optional burst lock; a routing FIFO steers read responses to their port.
module axi_ram_cmd_arb #(
    parameter int PORTS      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int INTERLEAVE = 0,
    parameter int RESP_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*ID_WIDTH-1:0]   s_cmd_id,
    input  logic [PORTS*ADDR_WIDTH-1:0] s_cmd_addr,
    input  logic [PORTS*DATA_WIDTH-1:0] s_cmd_wr_data,
    input  logic [PORTS*STRB_WIDTH-1:0] s_cmd_wr_strb,
    input  logic [PORTS-1:0]            s_cmd_rd,
    input  logic [PORTS-1:0]            s_cmd_last,
    input  logic [PORTS-1:0]            s_cmd_en,
    output logic [PORTS-1:0]            s_cmd_ready,
    output logic [DATA_WIDTH-1:0]       s_rd_resp_data,
    output logic [ID_WIDTH-1:0]         s_rd_resp_id,
    output logic                        s_rd_resp_last,
    output logic [PORTS-1:0]            s_rd_resp_valid,
    input  logic [PORTS-1:0]            s_rd_resp_ready,
    output logic [ID_WIDTH-1:0]         ram_cmd_id,
    output logic [ADDR_WIDTH-1:0]       ram_cmd_addr,
    output logic [DATA_WIDTH-1:0]       ram_cmd_wr_data,
    output logic [STRB_WIDTH-1:0]       ram_cmd_wr_strb,
    output logic                        ram_cmd_last,
    output logic                        ram_cmd_wr_en,
    output logic                        ram_cmd_rd_en,
    input  logic                        ram_cmd_ready,
    input  logic [ID_WIDTH-1:0]         ram_rd_resp_id,
    input  logic [DATA_WIDTH-1:0]       ram_rd_resp_data,
    input  logic                        ram_rd_resp_last,
    input  logic                        ram_rd_resp_valid,
    output logic                        ram_rd_resp_ready
);

    localparam int PW = $clog2(PORTS);
    localparam int DW = $clog2(RESP_DEPTH);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] lock_port;
    logic          lock_reg;
    logic [PW-1:0] gnt_idx;
    logic          gnt_valid;
    logic [PORTS-1:0] elig;

    logic [PW-1:0] route_mem [RESP_DEPTH];
    logic [DW-1:0] wr_ptr;
    logic [DW-1:0] rd_ptr;
    logic [DW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_nonempty;
    logic          push;
    logic          pop;
    logic [PW-1:0] head;

    assign fifo_nonempty = fifo_count != '0;
    assign fifo_full     = fifo_count == (DW+1)'(RESP_DEPTH);
    assign head          = route_mem[rd_ptr];

    // Which ports could take a beat now; a held lock masks everyone else.
    always_comb begin
        elig = '0;
        for (int i = 0; i < PORTS; i++) begin
            elig[i] = s_cmd_en[i] && ram_cmd_ready &&
                      (!s_cmd_rd[i] || !fifo_full);
            if (lock_reg && lock_port != PW'(i))
                elig[i] = 1'b0;
        end
    end

    // First eligible port after the last winner takes the grant.
    always_comb begin
        logic [PW-1:0] cand;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= PORTS; k++) begin
            cand = PW'((int'(rr_ptr) + k) % PORTS);
            if (!gnt_valid && elig[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign s_cmd_ready     = gnt_valid ? (PORTS'(1) << gnt_idx) : '0;
    assign ram_cmd_wr_en   = gnt_valid && !s_cmd_rd[gnt_idx];
    assign ram_cmd_rd_en   = gnt_valid && s_cmd_rd[gnt_idx];
    assign ram_cmd_id      = s_cmd_id[gnt_idx*ID_WIDTH +: ID_WIDTH];
    assign ram_cmd_addr    = s_cmd_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign ram_cmd_wr_data = s_cmd_wr_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign ram_cmd_wr_strb = s_cmd_wr_strb[gnt_idx*STRB_WIDTH +: STRB_WIDTH];
    assign ram_cmd_last    = s_cmd_last[gnt_idx];

    assign push = gnt_valid && s_cmd_rd[gnt_idx];
    assign pop  = ram_rd_resp_valid && ram_rd_resp_ready;

    assign ram_rd_resp_ready = fifo_nonempty && s_rd_resp_ready[head];
    assign s_rd_resp_valid   = (ram_rd_resp_valid && fifo_nonempty) ?
                               (PORTS'(1) << head) : '0;
    assign s_rd_resp_data    = ram_rd_resp_data;
    assign s_rd_resp_id      = ram_rd_resp_id;
    assign s_rd_resp_last    = ram_rd_resp_last;

    // Remember the last winner and hold the lock across a burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= PW'(PORTS - 1);
            lock_reg  <= 1'b0;
            lock_port <= '0;
        end else if (gnt_valid) begin
            rr_ptr <= gnt_idx;
            if (INTERLEAVE == 0) begin
                lock_reg  <= !s_cmd_last[gnt_idx];
                lock_port <= gnt_idx;
            end
        end
    end

    // Routing FIFO storage: one port index per outstanding read beat.
    always_ff @(posedge clk) begin
        if (push)
            route_mem[wr_ptr] <= gnt_idx;
    end

    // Routing FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_ram_cmd_arb.sv
// Bench for axi_ram_cmd_arb: queue-based reference model checked every
// cycle, plus directed scenarios with literal expected grants.
module tb_axi_ram_cmd_arb;

    localparam int P     = 3;
    localparam int DWD   = 32;
    localparam int AW    = 16;
    localparam int SW    = 4;
    localparam int IW    = 8;
    localparam int DEPTH = 2;
    localparam int IL    = 0;

    logic clk;
    logic rst;
    logic [P*IW-1:0]  s_cmd_id;
    logic [P*AW-1:0]  s_cmd_addr;
    logic [P*DWD-1:0] s_cmd_wr_data;
    logic [P*SW-1:0]  s_cmd_wr_strb;
    logic [P-1:0]     s_cmd_rd;
    logic [P-1:0]     s_cmd_last;
    logic [P-1:0]     s_cmd_en;
    logic [P-1:0]     s_rd_resp_ready;
    logic             ram_cmd_ready;
    logic [IW-1:0]    ram_rd_resp_id;
    logic [DWD-1:0]   ram_rd_resp_data;
    logic             ram_rd_resp_last;
    logic             ram_rd_resp_valid;

    logic [P-1:0]     s_cmd_ready;
    logic [DWD-1:0]   s_rd_resp_data;
    logic [IW-1:0]    s_rd_resp_id;
    logic             s_rd_resp_last;
    logic [P-1:0]     s_rd_resp_valid;
    logic [IW-1:0]    ram_cmd_id;
    logic [AW-1:0]    ram_cmd_addr;
    logic [DWD-1:0]   ram_cmd_wr_data;
    logic [SW-1:0]    ram_cmd_wr_strb;
    logic             ram_cmd_last;
    logic             ram_cmd_wr_en;
    logic             ram_cmd_rd_en;
    logic             ram_rd_resp_ready;

    logic [P-1:0]     i_s_cmd_ready;
    logic [DWD-1:0]   i_s_rd_resp_data;
    logic [IW-1:0]    i_s_rd_resp_id;
    logic             i_s_rd_resp_last;
    logic [P-1:0]     i_s_rd_resp_valid;
    logic [IW-1:0]    i_ram_cmd_id;
    logic [AW-1:0]    i_ram_cmd_addr;
    logic [DWD-1:0]   i_ram_cmd_wr_data;
    logic [SW-1:0]    i_ram_cmd_wr_strb;
    logic             i_ram_cmd_last;
    logic             i_ram_cmd_wr_en;
    logic             i_ram_cmd_rd_en;
    logic             i_ram_rd_resp_ready;

    axi_ram_cmd_arb #(
        .PORTS(P), .DATA_WIDTH(DWD), .ADDR_WIDTH(AW), .STRB_WIDTH(SW),
        .ID_WIDTH(IW), .INTERLEAVE(IL), .RESP_DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .rst(rst),
        .s_cmd_id(s_cmd_id), .s_cmd_addr(s_cmd_addr),
        .s_cmd_wr_data(s_cmd_wr_data), .s_cmd_wr_strb(s_cmd_wr_strb),
        .s_cmd_rd(s_cmd_rd), .s_cmd_last(s_cmd_last),
        .s_cmd_en(s_cmd_en), .s_cmd_ready(s_cmd_ready),
        .s_rd_resp_data(s_rd_resp_data), .s_rd_resp_id(s_rd_resp_id),
        .s_rd_resp_last(s_rd_resp_last), .s_rd_resp_valid(s_rd_resp_valid),
        .s_rd_resp_ready(s_rd_resp_ready),
        .ram_cmd_id(ram_cmd_id), .ram_cmd_addr(ram_cmd_addr),
        .ram_cmd_wr_data(ram_cmd_wr_data), .ram_cmd_wr_strb(ram_cmd_wr_strb),
        .ram_cmd_last(ram_cmd_last), .ram_cmd_wr_en(ram_cmd_wr_en),
        .ram_cmd_rd_en(ram_cmd_rd_en), .ram_cmd_ready(ram_cmd_ready),
        .ram_rd_resp_id(ram_rd_resp_id), .ram_rd_resp_data(ram_rd_resp_data),
        .ram_rd_resp_last(ram_rd_resp_last),
        .ram_rd_resp_valid(ram_rd_resp_valid),
        .ram_rd_resp_ready(ram_rd_resp_ready)
    );

    axi_ram_cmd_arb #(
        .PORTS(P), .DATA_WIDTH(DWD), .ADDR_WIDTH(AW), .STRB_WIDTH(SW),
        .ID_WIDTH(IW), .INTERLEAVE(1), .RESP_DEPTH(DEPTH)
    ) u_dut_il (
        .clk(clk), .rst(rst),
        .s_cmd_id(s_cmd_id), .s_cmd_addr(s_cmd_addr),
        .s_cmd_wr_data(s_cmd_wr_data), .s_cmd_wr_strb(s_cmd_wr_strb),
        .s_cmd_rd(s_cmd_rd), .s_cmd_last(s_cmd_last),
        .s_cmd_en(s_cmd_en), .s_cmd_ready(i_s_cmd_ready),
        .s_rd_resp_data(i_s_rd_resp_data), .s_rd_resp_id(i_s_rd_resp_id),
        .s_rd_resp_last(i_s_rd_resp_last),
        .s_rd_resp_valid(i_s_rd_resp_valid),
        .s_rd_resp_ready(s_rd_resp_ready),
        .ram_cmd_id(i_ram_cmd_id), .ram_cmd_addr(i_ram_cmd_addr),
        .ram_cmd_wr_data(i_ram_cmd_wr_data),
        .ram_cmd_wr_strb(i_ram_cmd_wr_strb),
        .ram_cmd_last(i_ram_cmd_last), .ram_cmd_wr_en(i_ram_cmd_wr_en),
        .ram_cmd_rd_en(i_ram_cmd_rd_en), .ram_cmd_ready(ram_cmd_ready),
        .ram_rd_resp_id(ram_rd_resp_id), .ram_rd_resp_data(ram_rd_resp_data),
        .ram_rd_resp_last(ram_rd_resp_last),
        .ram_rd_resp_valid(ram_rd_resp_valid),
        .ram_rd_resp_ready(i_ram_rd_resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_rr;
    bit m_lock;
    int m_lockp;
    int m_q[$];
    bit model_ok = 1'b0;
    int e_g;
    bit e_pop;

    // values observed at the last sample point
    logic [P-1:0] obs_ready;
    logic [P-1:0] obs_il_ready;
    logic [P-1:0] obs_rvalid;
    logic         obs_rram;
    logic         obs_wr_en;
    logic         obs_rd_en;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_eval();
        int bestd;
        int d;
        bit el;
        logic [P-1:0] exp_rdy;
        logic [P-1:0] exp_v;
        logic exp_rr;
        e_g = -1;
        bestd = P;
        for (int i = 0; i < P; i++) begin
            el = s_cmd_en[i] && ram_cmd_ready &&
                 (!s_cmd_rd[i] || m_q.size() < DEPTH) &&
                 (!m_lock || i == m_lockp);
            d = (i - m_rr - 1 + 2 * P) % P;
            if (el && d < bestd) begin
                bestd = d;
                e_g = i;
            end
        end
        exp_rdy = '0;
        exp_v = '0;
        exp_rr = 1'b0;
        if (e_g >= 0) exp_rdy[e_g] = 1'b1;
        if (m_q.size() > 0) begin
            exp_rr = s_rd_resp_ready[m_q[0]];
            if (ram_rd_resp_valid) exp_v[m_q[0]] = 1'b1;
        end
        e_pop = exp_rr && ram_rd_resp_valid;
        if (!model_ok) return;
        check("s_cmd_ready", 64'(s_cmd_ready), 64'(exp_rdy));
        if (e_g >= 0) begin
            check("wr_en", 64'(ram_cmd_wr_en), 64'(!s_cmd_rd[e_g]));
            check("rd_en", 64'(ram_cmd_rd_en), 64'(s_cmd_rd[e_g]));
            check("cmd_id", 64'(ram_cmd_id), 64'(s_cmd_id[e_g*IW +: IW]));
            check("cmd_addr", 64'(ram_cmd_addr),
                  64'(s_cmd_addr[e_g*AW +: AW]));
            check("cmd_data", 64'(ram_cmd_wr_data),
                  64'(s_cmd_wr_data[e_g*DWD +: DWD]));
            check("cmd_strb", 64'(ram_cmd_wr_strb),
                  64'(s_cmd_wr_strb[e_g*SW +: SW]));
            check("cmd_last", 64'(ram_cmd_last), 64'(s_cmd_last[e_g]));
        end else begin
            check("idle_en", 64'({ram_cmd_wr_en, ram_cmd_rd_en}), 64'(0));
        end
        check("rsp_valid", 64'(s_rd_resp_valid), 64'(exp_v));
        check("rsp_ready", 64'(ram_rd_resp_ready), 64'(exp_rr));
        check("rsp_pass", 64'({s_rd_resp_last, s_rd_resp_id, s_rd_resp_data}),
              64'({ram_rd_resp_last, ram_rd_resp_id, ram_rd_resp_data}));
    endtask

    task automatic model_update();
        if (rst) begin
            m_rr = P - 1;
            m_lock = 1'b0;
            m_lockp = 0;
            m_q.delete();
            model_ok = 1'b1;
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (e_g >= 0) begin
                m_rr = e_g;
                if (IL == 0) begin
                    m_lock = !s_cmd_last[e_g];
                    m_lockp = e_g;
                end
                if (s_cmd_rd[e_g]) m_q.push_back(e_g);
            end
        end
    endtask

    // inputs are set at the falling edge; sample 1 time unit later
    task automatic step();
        #1;
        model_eval();
        obs_ready    = s_cmd_ready;
        obs_il_ready = i_s_cmd_ready;
        obs_rvalid   = s_rd_resp_valid;
        obs_rram     = ram_rd_resp_ready;
        obs_wr_en    = ram_cmd_wr_en;
        obs_rd_en    = ram_cmd_rd_en;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        s_cmd_id = '0;
        s_cmd_addr = '0;
        s_cmd_wr_data = '0;
        s_cmd_wr_strb = '0;
        s_cmd_rd = '0;
        s_cmd_last = '0;
        s_cmd_en = '0;
        s_rd_resp_ready = '0;
        ram_cmd_ready = 1'b0;
        ram_rd_resp_id = '0;
        ram_rd_resp_data = '0;
        ram_rd_resp_last = 1'b0;
        ram_rd_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < P; i++) begin
            s_cmd_id[i*IW +: IW] = IW'($urandom);
            s_cmd_addr[i*AW +: AW] = AW'($urandom);
            s_cmd_wr_data[i*DWD +: DWD] = $urandom;
            s_cmd_wr_strb[i*SW +: SW] = SW'($urandom);
        end
        s_cmd_en = P'($urandom);
        s_cmd_rd = P'($urandom);
        s_cmd_last = P'($urandom);
        s_rd_resp_ready = P'($urandom);
        ram_cmd_ready = ($urandom_range(0, 3) != 0);
        ram_rd_resp_id = IW'($urandom);
        ram_rd_resp_data = $urandom;
        ram_rd_resp_last = 1'($urandom);
        ram_rd_resp_valid = 1'($urandom);
    endtask

    initial begin
        int beat;
        idle();
        rst = 1'b1;
        @(negedge clk);
        do_reset();

        // reset state with idle inputs
        step();
        check("rst_ready", 64'(obs_ready), 64'(0));
        check("rst_en", 64'({obs_wr_en, obs_rd_en}), 64'(0));
        check("rst_rvalid", 64'(obs_rvalid), 64'(0));

        // two ports streaming single-beat writes alternate
        do_reset();
        s_cmd_en = 3'b011;
        s_cmd_last = 3'b111;
        ram_cmd_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            s_cmd_wr_data = {3{$urandom}};
            step();
            check("alt_grant", 64'(obs_ready), (c % 2) ? 64'h2 : 64'h1);
            check("alt_wr_en", 64'(obs_wr_en), 64'(1));
        end

        // 4-beat burst on port 0 against a streaming port 1
        do_reset();
        beat = 0;
        ram_cmd_ready = 1'b1;
        s_cmd_en[1] = 1'b1;
        s_cmd_last[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            s_cmd_en[0] = (beat < 4);
            s_cmd_last[0] = (beat == 3);
            step();
            if (obs_ready[0]) beat++;
            check("lock_grant", 64'(obs_ready), (c < 4) ? 64'h1 : 64'h2);
            if (c < 4)
                check("il_grant", 64'(obs_il_ready),
                      (c % 2) ? 64'h2 : 64'h1);
        end

        // routing FIFO full stalls the third read
        do_reset();
        ram_cmd_ready = 1'b1;
        s_rd_resp_ready = '1;
        s_cmd_en = 3'b001;
        s_cmd_rd = 3'b001;
        s_cmd_last = 3'b001;
        step();
        check("rd1_acc", 64'(obs_ready), 64'h1);
        step();
        check("rd2_acc", 64'(obs_ready), 64'h1);
        step();
        check("rd3_stall", 64'(obs_ready), 64'h0);
        ram_rd_resp_valid = 1'b1;
        ram_rd_resp_data = 32'hCAFE_0001;
        step();
        check("rd3_pop_stall", 64'(obs_ready), 64'h0);
        check("rd3_pop", 64'(obs_rram), 64'h1);
        ram_rd_resp_valid = 1'b0;
        step();
        check("rd3_acc", 64'(obs_ready), 64'h1);

        // responses routed back in command order
        do_reset();
        ram_cmd_ready = 1'b1;
        s_cmd_en = 3'b010;
        s_cmd_rd = 3'b011;
        s_cmd_last = 3'b011;
        s_cmd_id = {8'h00, 8'h11, 8'h22};
        step();
        check("route_g1", 64'(obs_ready), 64'h2);
        s_cmd_en = 3'b001;
        step();
        check("route_g0", 64'(obs_ready), 64'h1);
        s_cmd_en = '0;
        ram_rd_resp_valid = 1'b1;
        ram_rd_resp_id = 8'h11;
        s_rd_resp_ready = 3'b101;
        step();
        check("route_v1", 64'(obs_rvalid), 64'h2);
        check("route_hold", 64'(obs_rram), 64'h0);
        s_rd_resp_ready = '1;
        step();
        check("route_v1b", 64'(obs_rvalid), 64'h2);
        check("route_pop1", 64'(obs_rram), 64'h1);
        ram_rd_resp_id = 8'h22;
        step();
        check("route_v0", 64'(obs_rvalid), 64'h1);
        ram_rd_resp_valid = 1'b0;
        step();

        // RAM back-pressure leaves the round-robin pointer alone
        do_reset();
        s_cmd_en = 3'b011;
        s_cmd_last = 3'b111;
        ram_cmd_ready = 1'b1;
        step();
        check("bp_first", 64'(obs_ready), 64'h1);
        ram_cmd_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_ready", 64'(obs_ready), 64'h0);
            check("bp_en", 64'({obs_wr_en, obs_rd_en}), 64'h0);
        end
        ram_cmd_ready = 1'b1;
        step();
        check("bp_resume", 64'(obs_ready), 64'h2);

        // reset in the middle of a locked burst on port 1
        do_reset();
        ram_cmd_ready = 1'b1;
        s_cmd_en = 3'b010;
        s_cmd_last = 3'b000;
        step();
        check("mid_b1", 64'(obs_ready), 64'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_cmd_en = 3'b011;
        step();
        check("mid_after", 64'(obs_ready), 64'h1);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            randomize_inputs();
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
